// File: rtl/lwe_pkg.sv
// Shared constants, FSM state encoding and key-address helper for the LWE
// encryption sequencer.
package lwe_pkg;

    localparam int DEF_PLAINTEXT_WIDTH  = 8;
    localparam int DEF_CIPHERTEXT_WIDTH = 10;
    localparam int CIPHERTEXT_MODULUS   = 1 << DEF_CIPHERTEXT_WIDTH;
    localparam int DEF_BIG_N            = 30;
    localparam int DEF_LITTLE_N         = 2;
    localparam int DEF_KEY_RD_LATENCY   = 1;
    localparam int DEF_DELTA_SHIFT      = DEF_CIPHERTEXT_WIDTH - DEF_PLAINTEXT_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        EMIT,
        DONE
    } lwe_state_t;

    // Key RAM is column-major: all BIG_N rows of column 0, then column 1, ...
    function automatic int unsigned key_addr(input int unsigned col,
                                             input int unsigned row,
                                             input int unsigned big_n);
        return col * big_n + row;
    endfunction

endpackage

// File: rtl/lwe_col_accumulator.sv
// Mod-2^CW column accumulator that tracks outstanding key reads and folds
// returning data (and optionally the scaled message) into the running sum.
module lwe_col_accumulator
    import lwe_pkg::*;
#(
    parameter int CW  = DEF_CIPHERTEXT_WIDTH,
    parameter int PW  = DEF_PLAINTEXT_WIDTH,
    parameter int LAT = DEF_KEY_RD_LATENCY
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          issue,
    input  logic [CW-1:0] rd_data,
    input  logic          add_msg,
    input  logic [PW-1:0] msg,
    output logic [CW-1:0] sum,
    output logic          idle
);

    localparam int SHIFT = CW - PW;
    localparam int CNT_W = $clog2(LAT + 2) + 1;

    logic [LAT-1:0] vld_reg;
    logic [CW-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic           ret;
    logic [CW-1:0]  msg_scaled;

    // Issue strobe delayed by the RAM latency marks the cycle data is valid.
    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_vld
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst || clr) vld_reg[gi] <= 1'b0;
                    else            vld_reg[gi] <= issue;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst || clr) vld_reg[gi] <= 1'b0;
                    else            vld_reg[gi] <= vld_reg[gi-1];
                end
            end
        end
    endgenerate

    assign ret        = vld_reg[LAT-1];
    assign msg_scaled = CW'(msg) << SHIFT;

    always_comb begin
        acc_next = acc_reg + (ret ? rd_data : '0) + (add_msg ? msg_scaled : '0);
        cnt_next = cnt_reg + CNT_W'(issue) - CNT_W'(ret);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
        end
    end

    assign sum  = acc_reg;
    // A read returning this cycle is already folded in by the next edge.
    assign idle = (cnt_reg == CNT_W'(ret));

endmodule

// File: rtl/lwe_encrypt_ctrl.sv
// LWE encryption sequencer: walks selected key rows column by column,
// accumulates each column mod q and streams LITTLE_N+1 ciphertext words.
module lwe_encrypt_ctrl
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_WIDTH  = DEF_PLAINTEXT_WIDTH,
    parameter int CIPHERTEXT_WIDTH = DEF_CIPHERTEXT_WIDTH,
    parameter int BIG_N            = DEF_BIG_N,
    parameter int LITTLE_N         = DEF_LITTLE_N,
    parameter int KEY_RD_LATENCY   = DEF_KEY_RD_LATENCY,
    parameter int ADDR_WIDTH       = $clog2(BIG_N * (LITTLE_N + 1)),
    localparam int IW              = (LITTLE_N > 0) ? $clog2(LITTLE_N + 1) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        ready,
    input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
    input  logic [BIG_N-1:0]            noise_select,
    output logic                        key_rd_en,
    output logic [ADDR_WIDTH-1:0]       key_rd_addr,
    input  logic [CIPHERTEXT_WIDTH-1:0] key_rd_data,
    output logic                        ct_valid,
    input  logic                        ct_ready,
    output logic [CIPHERTEXT_WIDTH-1:0] ct_data,
    output logic [IW-1:0]               ct_index,
    output logic                        ct_last,
    output logic                        done
);

    localparam int RW = (BIG_N > 1) ? $clog2(BIG_N) : 1;

    lwe_state_t                 state_reg, state_next;
    logic [IW-1:0]              col_reg, col_next;
    logic [BIG_N-1:0]           mask_reg, mask_next;
    logic [BIG_N-1:0]           remain_reg, remain_next;
    logic [PLAINTEXT_WIDTH-1:0] pt_reg, pt_next;

    logic [RW-1:0]              ffs_idx;
    logic [BIG_N-1:0]           remain_clr;
    logic                       issue, clr, add_msg, acc_idle, last_col;
    logic [CIPHERTEXT_WIDTH-1:0] acc_sum;

    lwe_col_accumulator #(
        .CW (CIPHERTEXT_WIDTH),
        .PW (PLAINTEXT_WIDTH),
        .LAT(KEY_RD_LATENCY)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .issue  (issue),
        .rd_data(key_rd_data),
        .add_msg(add_msg),
        .msg    (pt_reg),
        .sum    (acc_sum),
        .idle   (acc_idle)
    );

    // Lowest set bit of the remaining mask; scan downward so the last hit wins.
    always_comb begin
        ffs_idx = '0;
        for (int i = BIG_N - 1; i >= 0; i--) begin
            if (remain_reg[i]) ffs_idx = RW'(i);
        end
    end

    assign remain_clr = remain_reg & (remain_reg - BIG_N'(1));
    assign last_col   = (col_reg == IW'(LITTLE_N));

    always_comb begin
        state_next  = state_reg;
        col_next    = col_reg;
        mask_next   = mask_reg;
        remain_next = remain_reg;
        pt_next     = pt_reg;
        issue       = 1'b0;
        clr         = 1'b0;
        add_msg     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    pt_next     = plaintext;
                    mask_next   = noise_select;
                    remain_next = noise_select;
                    col_next    = '0;
                    clr         = 1'b1;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (remain_reg == '0) begin
                    state_next = DRAIN;
                end else begin
                    issue       = 1'b1;
                    remain_next = remain_clr;
                    if (remain_clr == '0) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (acc_idle) begin
                    add_msg    = last_col;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (ct_ready) begin
                    if (last_col) begin
                        state_next = DONE;
                    end else begin
                        col_next    = col_reg + IW'(1);
                        clr         = 1'b1;
                        remain_next = mask_reg;
                        state_next  = ISSUE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            col_reg    <= '0;
            mask_reg   <= '0;
            remain_reg <= '0;
            pt_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            mask_reg   <= mask_next;
            remain_reg <= remain_next;
            pt_reg     <= pt_next;
        end
    end

    assign ready       = (state_reg == IDLE);
    assign key_rd_en   = issue;
    assign key_rd_addr = issue ? ADDR_WIDTH'(key_addr(32'(col_reg), 32'(ffs_idx), BIG_N))
                               : '0;
    assign ct_valid    = (state_reg == EMIT);
    assign ct_data     = ct_valid ? acc_sum : '0;
    assign ct_index    = ct_valid ? col_reg : '0;
    assign ct_last     = ct_valid && last_col;
    assign done        = (state_reg == DONE);

endmodule

// File: doc/lwe_encrypt_ctrl.md
Name: lwe_encrypt_ctrl

Overview:
- Sequencer for the LWE public-key encryption datapath.
- Per message, it accepts a plaintext and an N-bit noise-select subset mask, then walks the public-key memory column by column.
- It issues reads only for selected rows, accumulates each column mod q, and adds the scaled message to the final (b) column.
- It streams the LITTLE_N+1 ciphertext words out over a valid/ready interface. It sits between the key RAM / noise RNG and the ciphertext consumer.

Parameters:
- PLAINTEXT_WIDTH, 8, log2(p); message bits.
- CIPHERTEXT_WIDTH, 10, log2(q); q = CIPHERTEXT_MODULUS = 2^CIPHERTEXT_WIDTH.
- BIG_N, 30, public-key rows (N).
- LITTLE_N, 2, secret dimension (n); ciphertext has LITTLE_N+1 words.
- KEY_RD_LATENCY, 1, key RAM read latency in cycles (>=1).
- ADDR_WIDTH, $clog2(BIG_N*(LITTLE_N+1)), key RAM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin encryption; sampled only when ready=1.
- ready  out  1  idle, can accept start.
- plaintext  in  PLAINTEXT_WIDTH  message; latched on accepted start.
- noise_select  in  BIG_N  subset mask; bit i selects key row i; latched on accepted start.
- key_rd_en  out  1  key RAM read strobe.
- key_rd_addr  out  ADDR_WIDTH  = col*BIG_N + row.
- key_rd_data  in  CIPHERTEXT_WIDTH  valid KEY_RD_LATENCY cycles after key_rd_en.
- ct_valid  out  1  ciphertext word valid.
- ct_ready  in  1  consumer accepts word.
- ct_data  out  CIPHERTEXT_WIDTH  ciphertext word.
- ct_index  out  $clog2(LITTLE_N+1)  column index of ct_data.
- ct_last  out  1  high with word index LITTLE_N.
- done  out  1  one-cycle pulse after the last word handshakes.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE; ready=1.
  - key_rd_en, ct_valid, ct_last, done = 0; ct_data, ct_index, key_rd_addr = 0.
  - Accumulator and latched mask are cleared.
- States: IDLE -> ISSUE -> DRAIN -> EMIT -> (ISSUE for next column | DONE) -> IDLE.
- IDLE:
  - start && ready latches plaintext and noise_select.
  - Sets col=0, clears acc, loads remaining mask = noise_select, goes to ISSUE.
- ISSUE:
  - Each cycle, a find-first-set picks the lowest set bit r of the remaining mask.
  - Drives key_rd_en=1, key_rd_addr=col*BIG_N+r, and clears bit r from the remaining mask.
  - The cycle that issues the last set bit moves to DRAIN.
  - If the mask is empty on entry, go straight to DRAIN with no reads issued.
  - Exactly popcount(noise_select) reads per column; unselected rows cost zero cycles.
- Read return and accumulation:
  - A read issued in cycle t returns data in cycle t+KEY_RD_LATENCY.
  - The returned data is added into acc at the end of that cycle: acc = (acc + key_rd_data) mod 2^CIPHERTEXT_WIDTH. Truncate; no carry out.
  - An in-flight counter tracks outstanding reads.
- DRAIN:
  - Wait until the in-flight count is 0.
  - If col==LITTLE_N, add plaintext << (CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH), mod q.
  - Go to EMIT. The first ct_valid therefore appears KEY_RD_LATENCY+1 cycles after the last issue.
- EMIT:
  - ct_valid=1, ct_data=acc, ct_index=col, ct_last=(col==LITTLE_N).
  - All held stable until ct_ready.
  - On handshake: if the column was not the last, col++, clear acc, reload the remaining mask from the latched mask, go to ISSUE. Otherwise go to DONE.
- DONE: pulse done=1 for one cycle, return to IDLE; ready=1 the following cycle.
- Busy behaviour: start while ready=0 is ignored; plaintext and noise_select changes while busy have no effect.
- Reset mid-operation: takes effect on the next edge from any state. In-flight read returns are ignored (in-flight counter cleared). No ct_valid or done follows.
- ct_ready held high: EMIT lasts exactly 1 cycle.
- Column columns 0..LITTLE_N-1 are the a vector; column LITTLE_N is b.

Decomposition:
- Shared package lwe_pkg holds:
  - width/modulus constants and the delta shift (CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH);
  - the state enum {IDLE, ISSUE, DRAIN, EMIT, DONE};
  - the address helper col*BIG_N+row.
- One natural sub-module: lwe_col_accumulator.
  - Holds the mod-q accumulator and the in-flight counter.
  - Ports: clr, issue, rd_data, add_msg, msg, sum, idle.
- The FSM, find-first-set and output regs stay in lwe_encrypt_ctrl.

Test Plan:
- Common setup for all scenarios:
  - Default parameters; KEY_RD_LATENCY=1.
  - Key RAM model holds K[col][row].
  - ct_ready=1 unless stated otherwise.
1. noise_select=0, plaintext=5 -> words (0,0,20), ct_index 0,1,2, ct_last on the third word. Zero key_rd_en cycles; done pulses once.
2. noise_select=bits{0,3}, plaintext=5; K[0][0]=100, K[0][3]=200, K[1][0]=900, K[1][3]=200, K[2][0]=10, K[2][3]=20:
   - words are 300, 76 (1100 mod 1024) and 50;
   - reads go to addr 0,3,30,33,60,63 in that order, two issue cycles per column.
3. noise_select=all ones, all keys=1, plaintext=0 -> every word is 30. Exactly 90 key_rd_en cycles; addresses are strictly increasing.
4. Same stimulus as scenario 2 with ct_ready low for 5 cycles during the second word -> ct_data=76 and ct_index=1 are held stable. No extra reads are issued; results are unchanged.
5. start pulsed again mid-column with a different plaintext and mask -> ignored; output identical to scenario 2.
6. rst asserted during ISSUE of column 1 -> next cycle ready=1, ct_valid=0, done=0. A fresh start with scenario 1 stimulus yields (0,0,20).
